aes_enc_feeder: RTL
===================

# aes_enc_feeder

Upstream feeder for the pipelined AES-128 encryption core (`AES_enc`). It accepts plaintext blocks over a valid/ready stream and buffers them in a small FIFO. It sequences key loading via a one-cycle `fsm_en` pulse and the fixed key-expansion wait, then issues one block per cycle into the non-stallable core. A matched-latency valid shift register tags the core's ciphertext output as `m_valid`/`m_data`.

## Interface
- `KEY_WAIT`, 10: idle cycles after the `fsm_en` pulse before the first block may be issued.
- `PIPE_LAT`, 11: cycles from the edge that loads `core_in` to the edge where `core_out` carries that block's result.
- `FIFO_DEPTH`, 4: plaintext FIFO entries; power of two, ≥2.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `key_in`  in  128  cipher key, sampled when `key_load`=1.
- `key_load`  in  1  one-cycle request to (re)load the key.
- `s_valid`  in  1  plaintext valid.
- `s_data`  in  128  plaintext block.
- `s_ready`  out  1  FIFO can accept; equals !full.
- `core_in`  out  128  registered block to core `IN`.
- `core_key`  out  128  registered key to core `KEY`.
- `core_fsm_en`  out  1  registered one-cycle pulse to core `fsm_en`.
- `core_out`  in  128  core `OUT`.
- `m_valid`  out  1  `m_data` holds a ciphertext this cycle.
- `m_data`  out  128  combinational pass-through of `core_out`.
- `key_ready`  out  1  high in RUN state.

## Operation
- States: NOKEY, KEYGEN, RUN, DRAIN.
  - NOKEY: no blocks issued.
    - `key_load` → `core_key`←`key_in`, `core_fsm_en`←1, wait counter←0, go to KEYGEN.
  - KEYGEN: `core_fsm_en` drops after one cycle. Counter increments each cycle after the pulse.
    - Counter reaches `KEY_WAIT` → RUN.
    - `key_load` in KEYGEN restarts it: new key, new pulse, counter←0.
  - RUN: each edge with FIFO non-empty pops the head into `core_in` and shifts 1 into the valid shift register `vsr[PIPE_LAT-1:0]`.
    - FIFO empty → `core_in`←0, shift 0.
    - `key_load` → capture `key_in` into `pend_key`, go to DRAIN. No pop on that edge.
  - DRAIN: no pops; `vsr` keeps shifting zeros.
    - A further `key_load` overwrites `pend_key`.
    - `vsr` all-zero → `core_key`←`pend_key`, pulse `core_fsm_en`, counter←0, go to KEYGEN.
- `core_key` never changes while `vsr` is non-zero.
- `m_valid` = `vsr[PIPE_LAT-1]`; `m_data` = `core_out`. There is no output backpressure, and the consumer must take every `m_valid` beat.
- FIFO:
  - Push when `s_valid && s_ready`.
  - Push and pop in the same cycle are allowed, with count unchanged.
  - When full, `s_ready`=0 even if a pop occurs that cycle; `s_ready` is registered from count.
  - Blocks are accepted in any state, including NOKEY, up to depth.
  - Pointers wrap modulo `FIFO_DEPTH`. Count width is log2(depth)+1.
- Order preserved: ciphertext order equals plaintext acceptance order.

## Timing
- Reset (`rst`=0, asynchronous):
  - Outputs: `s_ready`=1 once reset is released; `core_in`=0, `core_key`=0, `core_fsm_en`=0, `m_valid`=0, `key_ready`=0.
  - Internal: FIFO empty, `vsr`=0, state NOKEY.
  - Reset mid-operation discards FIFO contents and in-flight tags. No spurious `m_valid` follows.
- Key load sampled at edge e0:
  - `core_fsm_en` is high between e0 and e0+1.
  - RUN is entered at e0+1+`KEY_WAIT`.
  - The earliest `core_in` load is at e0+2+`KEY_WAIT`, i.e. e0+12 with defaults.
- Block loaded into `core_in` at edge t → `m_valid`=1 between edges t+`PIPE_LAT` and t+`PIPE_LAT`+1.
- Throughput: one block per cycle in RUN while the FIFO is non-empty.
- Input-to-issue latency: a push at edge t into an empty FIFO in RUN is popped at edge t+1, giving a minimum of 1+`PIPE_LAT` cycles from acceptance to `m_valid`.
- DRAIN lasts at most `PIPE_LAT` cycles after the last issue, then the KEYGEN timing above applies.

## Test plan
- Reset, then `key_load` with key 000102030405060708090A0B0C0D0E0F, push 00112233445566778899AABBCCDDEEFF → `core_fsm_en` is a single 1-cycle pulse. The first `core_in` load occurs exactly 12 edges after the `key_load` edge. One `m_valid` follows 11 cycles later with `m_data`=69C4E0D86A7B0430D8CDB78070B4C55A.
- Same key, push 11 blocks back-to-back, including all-zero and all-one blocks → 11 consecutive `m_valid` cycles in order. The zero block gives C6A13B37878F5B826F4F8162A1C8D879, and FFFF…FF gives 3C441F32CE07822364D7A2990E50BB13.
- Push 6 blocks while in NOKEY → `s_ready` drops after 4 accepts and the remaining 2 stall. After key load, all 6 emerge in order, and `s_ready` reasserts once pops start.
- Issue `key_load` mid-stream in RUN with 3 blocks in flight → issue stops, the 3 results complete under the old key, then the `fsm_en` pulse carries the new key. The remaining FIFO blocks encrypt under the new key.
- Issue `key_load` twice in KEYGEN, 5 cycles apart → the counter restarts, the second key is used, and RUN is entered 11 edges after the second load.
- Assert `rst` low for 1 cycle with 5 blocks in flight → all outputs return to reset values immediately, with no `m_valid` for the 5 blocks and `key_ready`=0.

Source files
------------

// File: rtl/aes_enc_feeder_if.sv
// aes_enc_feeder_if
//   Stream bundle around the AES feeder.
//   s_valid / s_data / s_ready : plaintext valid/ready stream into the feeder.
//   m_valid / m_data           : ciphertext tag stream out of the feeder (no backpressure).
//   Modports:
//     slave  - the feeder side (consumes s_*, produces m_*).
//     master - the producer/consumer environment around the feeder.
interface aes_enc_feeder_if;
  logic         s_valid;
  logic [127:0] s_data;
  logic         s_ready;
  logic         m_valid;
  logic [127:0] m_data;

  modport slave (
    input  s_valid,
    input  s_data,
    output s_ready,
    output m_valid,
    output m_data
  );

  modport master (
    output s_valid,
    output s_data,
    input  s_ready,
    input  m_valid,
    input  m_data
  );
endinterface

// File: rtl/aes_enc_feeder.sv
// aes_enc_feeder
//   Front end for the pipelined, non-stallable AES-128 encryption core.
//   Buffers plaintext in a small FIFO, sequences key loading (one-cycle
//   fsm_en pulse plus fixed key-expansion wait), issues one block per cycle
//   while keyed, and tags the core's ciphertext output with a valid bit
//   carried through a latency-matched shift register.
//
//   Ports:
//     clk          rising-edge clock
//     rst          asynchronous active-low reset
//     key_in       cipher key, sampled with key_load
//     key_load     one-cycle (re)load request
//     bus          aes_enc_feeder_if.slave: s_valid/s_data/s_ready in,
//                  m_valid/m_data out (m_data = core_out)
//     core_in      registered block to core IN
//     core_key     registered key to core KEY
//     core_fsm_en  registered one-cycle pulse to core fsm_en
//     core_out     core OUT
//     key_ready    high while blocks may be issued (RUN)
module aes_enc_feeder #(
  parameter int unsigned KEY_WAIT   = 10,
  parameter int unsigned PIPE_LAT   = 11,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [127:0]          key_in,
  input  logic                  key_load,
  aes_enc_feeder_if.slave       bus,
  output logic [127:0]          core_in,
  output logic [127:0]          core_key,
  output logic                  core_fsm_en,
  input  logic [127:0]          core_out,
  output logic                  key_ready
);

  localparam int unsigned AW = (FIFO_DEPTH < 2) ? 1 : $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned KW = (KEY_WAIT < 1) ? 1 : $clog2(KEY_WAIT + 1);

  typedef enum logic [1:0] {
    NOKEY,
    KEYGEN,
    RUN,
    DRAIN
  } state_t;

  state_t state, state_nx;

  // FIFO storage
  logic [127:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty, push, pop;

  // key sequencing
  logic [KW-1:0] cnt, cnt_nx;
  logic [127:0]  pend_key, pend_nx, key_nx;
  logic          pulse;

  // in-flight tagging
  logic                issue_q;
  logic [PIPE_LAT-1:0] vsr, vsr_nx;
  logic                drained;

  assign full        = (count == CW'(FIFO_DEPTH));
  assign empty       = (count == '0);
  assign push        = bus.s_valid && !full;
  assign bus.s_ready = !full;

  // core_in is loaded at the pop edge and issue_q is set on that same edge;
  // feeding vsr from issue_q (not from pop) puts the tag at vsr[PIPE_LAT-1]
  // exactly PIPE_LAT edges after core_in was loaded, lining up with core_out.
  assign bus.m_valid = vsr[PIPE_LAT-1];
  assign bus.m_data  = core_out;
  assign key_ready   = (state == RUN);

  assign drained = (vsr == '0) && !issue_q;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pend_nx  = pend_key;
    key_nx   = core_key;
    pulse    = 1'b0;
    pop      = 1'b0;

    vsr_nx    = vsr << 1;
    vsr_nx[0] = issue_q;

    unique case (state)
      NOKEY: begin
        if (key_load) begin
          key_nx   = key_in;
          pulse    = 1'b1;
          cnt_nx   = '0;
          state_nx = KEYGEN;
        end
      end
      KEYGEN: begin
        if (key_load) begin
          key_nx = key_in;
          pulse  = 1'b1;
          cnt_nx = '0;
        end else if (cnt == KW'(KEY_WAIT)) begin
          state_nx = RUN;
        end else begin
          cnt_nx = cnt + KW'(1);
        end
      end
      RUN: begin
        if (key_load) begin
          pend_nx  = key_in;
          state_nx = DRAIN;
        end else begin
          pop = !empty;
        end
      end
      DRAIN: begin
        if (drained) begin
          // a key_load arriving on the exit edge is the newest request
          key_nx   = key_load ? key_in : pend_key;
          pulse    = 1'b1;
          cnt_nx   = '0;
          state_nx = KEYGEN;
        end else if (key_load) begin
          pend_nx = key_in;
        end
      end
      default: state_nx = NOKEY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= NOKEY;
      cnt         <= '0;
      pend_key    <= '0;
      core_key    <= '0;
      core_fsm_en <= 1'b0;
      core_in     <= '0;
      issue_q     <= 1'b0;
      vsr         <= '0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      pend_key    <= pend_nx;
      core_key    <= key_nx;
      core_fsm_en <= pulse;
      core_in     <= pop ? mem[rd_ptr] : '0;
      issue_q     <= pop;
      vsr         <= vsr_nx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.s_data;
  end

endmodule
